// File: rtl/xfer_seq_ctrl.sv
// Transfer sequencer: fixed-latency ack, start pulse, beat tracking and a bounded retry loop.
// Optional RUN watchdog is enabled by defining XFER_SEQ_TIMEOUT_EN.
module xfer_seq_ctrl #(
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned ACK_LAT   = 5,
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned RETRY_CYC = 4
`ifdef XFER_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT   = 64
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [LEN_W-1:0] len,
    input  logic             beat_done,
    input  logic             fault,
    input  logic             abort,
    output logic             ack,
    output logic             start,
    output logic             rdy,
    output logic             enable,
    output logic             rt,
    output logic             endd,
    output logic             stop,
    output logic             er,
    output logic             interrupt,
    output logic             status_valid,
    output logic [1:0]       status
);

    localparam int unsigned AckW = (ACK_LAT > 1) ? $clog2(ACK_LAT) : 1;
    localparam int unsigned RcW  = (RETRY_CYC > 1) ? $clog2(RETRY_CYC) : 1;
    localparam int unsigned RtW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        StIdle, StAckWait, StStart, StRun, StRetry, StDone, StStop, StErr
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [AckW-1:0]   ack_cnt_q, ack_cnt_d;
    logic [RcW-1:0]    rty_cyc_q, rty_cyc_d;
    logic [RtW-1:0]    retry_cnt_q, retry_cnt_d;
    logic [1:0]        status_d;
    logic              ack_d, start_d, rdy_d, enable_d, rt_d, endd_d, stop_d, er_d, intr_d;
    logic              fault_eff;

`ifdef XFER_SEQ_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    logic [WdW-1:0] wd_q, wd_d;
    logic           timeout_hit;

    assign timeout_hit = (state_q == StRun) && !beat_done && (wd_q == WdW'(TIMEOUT - 1));
    assign fault_eff   = fault | timeout_hit;

    always_comb begin
        wd_d = wd_q;
        if (state_q == StRun) begin
            wd_d = beat_done ? '0 : wd_q + WdW'(1);
        end
        // Fresh window every time RUN is (re)entered.
        if (state_d == StRun && state_q != StRun) begin
            wd_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) wd_q <= '0;
        else      wd_q <= wd_d;
    end
`else
    assign fault_eff = fault;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        ack_cnt_d   = ack_cnt_q;
        rty_cyc_d   = rty_cyc_q;
        retry_cnt_d = retry_cnt_q;

        case (state_q)
            StIdle: begin
                if (req) begin
                    len_d     = len;
                    ack_cnt_d = AckW'(ACK_LAT - 1);
                    state_d   = StAckWait;
                end
            end
            StAckWait: begin
                if (ack_cnt_q == '0) state_d = StStart;
                else                 ack_cnt_d = ack_cnt_q - AckW'(1);
            end
            StStart: begin
                remaining_d = len_q;
                retry_cnt_d = '0;
                state_d     = (len_q == '0) ? StDone : StRun;
            end
            StRun: begin
                if (abort) begin
                    state_d = StStop;
                end else if (fault_eff) begin
                    if (retry_cnt_q < RtW'(MAX_RETRY)) begin
                        retry_cnt_d = retry_cnt_q + RtW'(1);
                        rty_cyc_d   = RcW'(RETRY_CYC - 1);
                        state_d     = StRetry;
                    end else begin
                        state_d = StErr;
                    end
                end else if (beat_done) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) state_d = StDone;
                end
            end
            StRetry: begin
                if (abort)                  state_d = StStop;
                else if (rty_cyc_q == '0)   state_d = StRun;
                else                        rty_cyc_d = rty_cyc_q - RcW'(1);
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered decodes of the upcoming state.
        ack_d    = (state_d == StAckWait) && (ack_cnt_d == '0);
        start_d  = (state_d == StStart);
        rdy_d    = (state_d != StIdle) && (state_d != StAckWait);
        enable_d = (state_d == StRun);
        rt_d     = (state_d == StRetry);
        endd_d   = (state_d == StDone);
        stop_d   = (state_d == StStop);
        er_d     = (state_d == StErr);
        intr_d   = (state_q == StDone) || (state_q == StStop) || (state_q == StErr);

        status_d = status;
        if (state_d == StStart)      status_d = 2'b00;
        else if (state_q == StDone)  status_d = 2'b01;
        else if (state_q == StStop)  status_d = 2'b10;
        else if (state_q == StErr)   status_d = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            len_q        <= '0;
            remaining_q  <= '0;
            ack_cnt_q    <= '0;
            rty_cyc_q    <= '0;
            retry_cnt_q  <= '0;
            ack          <= 1'b0;
            start        <= 1'b0;
            rdy          <= 1'b0;
            enable       <= 1'b0;
            rt           <= 1'b0;
            endd         <= 1'b0;
            stop         <= 1'b0;
            er           <= 1'b0;
            interrupt    <= 1'b0;
            status_valid <= 1'b0;
            status       <= 2'b00;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            remaining_q  <= remaining_d;
            ack_cnt_q    <= ack_cnt_d;
            rty_cyc_q    <= rty_cyc_d;
            retry_cnt_q  <= retry_cnt_d;
            ack          <= ack_d;
            start        <= start_d;
            rdy          <= rdy_d;
            enable       <= enable_d;
            rt           <= rt_d;
            endd         <= endd_d;
            stop         <= stop_d;
            er           <= er_d;
            interrupt    <= intr_d;
            status_valid <= intr_d;
            status       <= status_d;
        end
    end

endmodule

// File: tb/tb_xfer_seq_ctrl.sv
// Scoreboard bench for xfer_seq_ctrl: directed stimulus pushes expected output events,
// a negedge monitor pops and compares whenever the DUT shows a pulse/retry output.
module tb_xfer_seq_ctrl;

    localparam int unsigned LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             beat_done = 1'b0;
    logic             fault = 1'b0;
    logic             abort = 1'b0;
    logic             ack, start, rdy, enable, rt, endd, stop, er, interrupt, status_valid;
    logic [1:0]       status;

    xfer_seq_ctrl #(
        .LEN_W    (LEN_W),
        .ACK_LAT  (5),
        .MAX_RETRY(2),
        .RETRY_CYC(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .len         (len),
        .beat_done   (beat_done),
        .fault       (fault),
        .abort       (abort),
        .ack         (ack),
        .start       (start),
        .rdy         (rdy),
        .enable      (enable),
        .rt          (rt),
        .endd        (endd),
        .stop        (stop),
        .er          (er),
        .interrupt   (interrupt),
        .status_valid(status_valid),
        .status      (status)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [11:0] v;
    } ev_t;

    ev_t q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // {ack,start,rdy,enable,rt,endd,stop,er,interrupt,status_valid,status[1:0]}
    logic [11:0] act;
    assign act = {ack, start, rdy, enable, rt, endd, stop, er, interrupt, status_valid, status};

    localparam logic [9:0] EvMask = 10'b1100111111;

    function automatic logic [11:0] ov(bit a, bit s, bit r, bit e, bit t, bit d, bit p, bit x,
                                       bit i, bit v, logic [1:0] st);
        return {a, s, r, e, t, d, p, x, i, v, st};
    endfunction

    task automatic exp_ev(input int c, input logic [11:0] v);
        ev_t e;
        e.c = c;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic go(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_now(input string name, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst && ((act[11:2] & EvMask) != 10'd0)) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event @%0d: got %b expected none", cyc, act);
            end else begin
                e = q.pop_front();
                if (e.c != cyc || e.v !== act) begin
                    n_fail++;
                    $display("FAIL event @%0d: got %b expected %b at cycle %0d",
                             cyc, act, e.v, e.c);
                end
            end
        end
    end

    task automatic pulse_beat(input int n);
        go(n);
        beat_done = 1'b1;
        go(n + 1);
        beat_done = 1'b0;
    endtask

    task automatic issue_req(input int n, input logic [LEN_W-1:0] l);
        go(n);
        req = 1'b1;
        len = l;
        go(n + 1);
        req = 1'b0;
    endtask

    initial begin
        go(2);
        check_now("reset_outputs", 12'd0);
        go(3);
        rst = 1'b1;

        // Normal transfer, len=3
        exp_ev(15, ov(1,0,0,0,0,0,0,0,0,0,2'b00));
        exp_ev(16, ov(0,1,1,0,0,0,0,0,0,0,2'b00));
        exp_ev(25, ov(0,0,1,0,0,1,0,0,0,0,2'b00));
        exp_ev(26, ov(0,0,0,0,0,0,0,0,1,1,2'b01));
        issue_req(10, 8'd3);
        go(18);
        check_now("run_enable", ov(0,0,1,1,0,0,0,0,0,0,2'b00));
        pulse_beat(20);
        pulse_beat(22);
        pulse_beat(24);

        // Single retry, len=2, fault at 50; beat during RETRY ignored
        exp_ev(45, ov(1,0,0,0,0,0,0,0,0,0,2'b01));
        exp_ev(46, ov(0,1,1,0,0,0,0,0,0,0,2'b00));
        for (int c = 51; c <= 54; c++) exp_ev(c, ov(0,0,1,0,1,0,0,0,0,0,2'b00));
        exp_ev(60, ov(0,0,1,0,0,1,0,0,0,0,2'b00));
        exp_ev(61, ov(0,0,0,0,0,0,0,0,1,1,2'b01));
        issue_req(40, 8'd2);
        go(50);
        fault = 1'b1;
        go(51);
        fault = 1'b0;
        pulse_beat(52);
        go(55);
        check_now("retry_enable_back", ov(0,0,1,1,0,0,0,0,0,0,2'b00));
        pulse_beat(57);
        pulse_beat(59);

        // Retries exhausted, len=5
        exp_ev(75, ov(1,0,0,0,0,0,0,0,0,0,2'b01));
        exp_ev(76, ov(0,1,1,0,0,0,0,0,0,0,2'b00));
        for (int c = 79; c <= 82; c++) exp_ev(c, ov(0,0,1,0,1,0,0,0,0,0,2'b00));
        for (int c = 85; c <= 88; c++) exp_ev(c, ov(0,0,1,0,1,0,0,0,0,0,2'b00));
        exp_ev(91, ov(0,0,1,0,0,0,0,1,0,0,2'b00));
        exp_ev(92, ov(0,0,0,0,0,0,0,0,1,1,2'b11));
        issue_req(70, 8'd5);
        go(78); fault = 1'b1; go(79); fault = 1'b0;
        go(84); fault = 1'b1; go(85); fault = 1'b0;
        go(90); fault = 1'b1; go(91); fault = 1'b0;

        // Abort during RETRY; retry counter cleared at START so first fault retries
        exp_ev(105, ov(1,0,0,0,0,0,0,0,0,0,2'b11));
        exp_ev(106, ov(0,1,1,0,0,0,0,0,0,0,2'b00));
        exp_ev(109, ov(0,0,1,0,1,0,0,0,0,0,2'b00));
        exp_ev(110, ov(0,0,1,0,1,0,0,0,0,0,2'b00));
        exp_ev(111, ov(0,0,1,0,0,0,1,0,0,0,2'b00));
        exp_ev(112, ov(0,0,0,0,0,0,0,0,1,1,2'b10));
        issue_req(100, 8'd4);
        go(108); fault = 1'b1; go(109); fault = 1'b0;
        go(110); abort = 1'b1; go(111); abort = 1'b0;

        // Abort + fault + beat together in RUN: abort wins
        exp_ev(125, ov(1,0,0,0,0,0,0,0,0,0,2'b10));
        exp_ev(126, ov(0,1,1,0,0,0,0,0,0,0,2'b00));
        exp_ev(129, ov(0,0,1,0,0,0,1,0,0,0,2'b00));
        exp_ev(130, ov(0,0,0,0,0,0,0,0,1,1,2'b10));
        issue_req(120, 8'd1);
        go(128);
        abort = 1'b1; fault = 1'b1; beat_done = 1'b1;
        go(129);
        abort = 1'b0; fault = 1'b0; beat_done = 1'b0;

        // Zero length, then back-to-back req in the completion cycle
        exp_ev(145, ov(1,0,0,0,0,0,0,0,0,0,2'b10));
        exp_ev(146, ov(0,1,1,0,0,0,0,0,0,0,2'b00));
        exp_ev(147, ov(0,0,1,0,0,1,0,0,0,0,2'b00));
        exp_ev(148, ov(0,0,0,0,0,0,0,0,1,1,2'b01));
        exp_ev(153, ov(1,0,0,0,0,0,0,0,0,0,2'b01));
        exp_ev(154, ov(0,1,1,0,0,0,0,0,0,0,2'b00));
        exp_ev(157, ov(0,0,1,0,0,1,0,0,0,0,2'b00));
        exp_ev(158, ov(0,0,0,0,0,0,0,0,1,1,2'b01));
        issue_req(140, 8'd0);
        issue_req(148, 8'd1);
        pulse_beat(156);

        // Reset mid-RUN with remaining=2, then a normal transfer
        exp_ev(175, ov(1,0,0,0,0,0,0,0,0,0,2'b01));
        exp_ev(176, ov(0,1,1,0,0,0,0,0,0,0,2'b00));
        issue_req(170, 8'd3);
        pulse_beat(178);
        go(180);
        rst = 1'b0;
        go(181);
        rst = 1'b1;
        check_now("mid_run_reset", 12'd0);
        exp_ev(195, ov(1,0,0,0,0,0,0,0,0,0,2'b00));
        exp_ev(196, ov(0,1,1,0,0,0,0,0,0,0,2'b00));
        exp_ev(205, ov(0,0,1,0,0,1,0,0,0,0,2'b00));
        exp_ev(206, ov(0,0,0,0,0,0,0,0,1,1,2'b01));
        issue_req(190, 8'd3);
        pulse_beat(200);
        pulse_beat(202);
        pulse_beat(204);
        go(208);
        check_now("idle_after_completion", ov(0,0,0,0,0,0,0,0,0,0,2'b01));

        go(215);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d left expected 0 (next at cycle %0d)",
                     q.size(), q[0].c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
